alu8_issue_wb: RTL and testbench
================================

Name: alu8_issue_wb

Overview:
- Sequential front-end and writeback stage wrapped around the combinational alu8.
- Accepts one instruction per valid/ready handshake and reads two source operands from an internal 8-entry register file.
- Drives alu8 funSel/a/b from registered values, then writes the ALU result back to the destination register and holds a sticky zero flag.
- Sits directly upstream of alu8 as operand issue and directly downstream of it as result capture.

Parameters:
- DATA_W, 8, datapath width; must be 8 when paired with alu8.
- NREG, 8, number of registers; address width is clog2(NREG) = 3.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  block can accept an instruction.
- in_op  in  3  000 AND, 001 OR, 010 ADD, 011 SUB, 111 SLT, 100 LDI, 101/110 illegal.
- in_rd  in  3  destination register.
- in_rs1  in  3  source register A.
- in_rs2  in  3  source register B.
- in_imm  in  8  immediate; used by LDI only.
- alu_funSel  out  3  to alu8 funSel.
- alu_a  out  8  to alu8 a.
- alu_b  out  8  to alu8 b.
- alu_result  in  8  from alu8 result.
- alu_zeroFlag  in  1  from alu8 zeroFlag.
- done  out  1  one-cycle pulse: instruction retired.
- err  out  1  one-cycle pulse with done: illegal opcode.
- wb_data  out  8  value written (0 when err); valid while done=1.
- zero  out  1  sticky zero flag from last retired ALU op.
- dbg_addr  in  3  debug read address.
- dbg_data  out  8  combinational rf[dbg_addr].

Behaviour:
- Reset (rst=1 at a rising edge):
  - state goes to IDLE; all rf entries become 0x00.
  - outputs: in_ready=1, done=0, err=0, wb_data=0, zero=0, alu_funSel=0, alu_a=0, alu_b=0.
  - Reset has priority over everything, including mid-EXEC: the in-flight instruction is discarded with no writeback and no done.
- FSM has two states, IDLE and EXEC.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at an edge, latch op/rd/imm and the operands a_q=rf[rs1], b_q=rf[rs2] (read at that edge), then go to EXEC.
  - in_valid=0: stay in IDLE.
- EXEC:
  - in_ready=0; in_valid is ignored and the instruction fields may change freely.
  - alu_funSel=op_q, alu_a=a_q, alu_b=b_q; all are registers and stable for the whole cycle.
  - At the edge leaving EXEC (always to IDLE):
    - ALU ops (000/001/010/011/111): rf[rd_q] <= alu_result; zero <= alu_zeroFlag; wb_data <= alu_result.
    - LDI (100): rf[rd_q] <= imm_q; wb_data <= imm_q; zero unchanged; ALU outputs are ignored.
    - Illegal (101/110): no rf write, zero unchanged, wb_data <= 0, err <= 1.
    - done <= 1 for exactly one cycle, coincident with IDLE and in_ready=1.
- Timing:
  - Latency: accept at edge N, writeback and done rising at edge N+1.
  - Maximum throughput: one instruction per 2 cycles.
- Hazards:
  - Writeback at edge N+1 precedes the earliest next accept (edge N+2), so a dependent instruction always reads the updated value; no forwarding is needed.
  - rd may equal rs1 or rs2; operands are those latched at acceptance.
- Outputs between ops: alu_* outputs hold their last EXEC values while IDLE.
- dbg_data reflects rf after the write edge.
- Arithmetic is entirely inside alu8; carries and borrows wrap modulo 256.
- This block never modifies alu_result; SLT writes 0x01 or 0x00 as produced by alu8.

Test Plan:
- Reset, then LDI r1=0xCC and LDI r2=0xAA, then AND r3=r1,r2 -> done pulses 3 times; dbg r3=0x88; zero=0; wb_data=0x88 on the last done.
- LDI r5=0x04, then SUB r4=r5,r5 -> r4=0x00, zero=1. Then LDI r6=0x00 -> zero remains 1 (LDI does not touch the flag).
- LDI r1=0x02, LDI r2=0x04, SLT r3=r1,r2 -> r3=0x01. Then SLT r3=r2,r1 -> r3=0x00, zero=1.
- Hold in_valid=1 continuously with ADD r1=r1,r1 from r1=0x81 -> in_ready alternates 1/0, one accept per 2 cycles; r1 becomes 0x02 (wrap); next op reads 0x02 (no hazard).
- in_op=101 with rd=r7 -> done=1 and err=1 together; wb_data=0; r7 and zero unchanged.
- Accept ADD r3=r1,r2, assert rst during EXEC -> no done; all rf=0; zero=0; in_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/alu8_issue_wb_if.sv
// Bundle of the instruction handshake, the alu8 operand/result bus, the retire
// outputs and the debug read port of alu8_issue_wb.
interface alu8_issue_wb_if #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8
);
    localparam int AW = $clog2(NREG);

    // Instruction handshake
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [AW-1:0]     in_rd;
    logic [AW-1:0]     in_rs1;
    logic [AW-1:0]     in_rs2;
    logic [DATA_W-1:0] in_imm;

    // alu8 operand issue and result capture
    logic [2:0]        alu_funSel;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zeroFlag;

    // Retire status
    logic              done;
    logic              err;
    logic [DATA_W-1:0] wb_data;
    logic              zero;

    // Debug register-file read
    logic [AW-1:0]     dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
        input  alu_result, alu_zeroFlag, dbg_addr,
        output in_ready, alu_funSel, alu_a, alu_b,
        output done, err, wb_data, zero, dbg_data
    );

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
        output alu_result, alu_zeroFlag, dbg_addr,
        input  in_ready, alu_funSel, alu_a, alu_b,
        input  done, err, wb_data, zero, dbg_data
    );
endinterface

// File: rtl/alu8_issue_wb.sv
// Issue/writeback stage around the combinational alu8: accepts one
// instruction, presents registered operands to the ALU for one cycle, then
// writes the result (or an immediate) back to an internal register file.
module alu8_issue_wb #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu8_issue_wb_if.slave   bus
);
    localparam int AW = $clog2(NREG);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic              acceptS;
    logic              retireS;

    logic [DATA_W-1:0] rf [NREG];

    logic [2:0]        opQ;
    logic [AW-1:0]     rdQ;
    logic [DATA_W-1:0] immQ;
    logic [DATA_W-1:0] aQ;
    logic [DATA_W-1:0] bQ;

    logic              doneQ;
    logic              errQ;
    logic [DATA_W-1:0] wbDataQ;
    logic              zeroQ;

    logic              wbEnS;
    logic [DATA_W-1:0] wbValS;
    logic              illegalS;
    logic              zeroUpdS;

    // State register; reset abandons any instruction in EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state plus accept/retire strobes; EXEC always lasts one cycle.
    always_comb begin
        stateNext = state;
        acceptS   = 1'b0;
        retireS   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    acceptS   = 1'b1;
                    stateNext = EXEC;
                end else begin
                    stateNext = IDLE;
                end
            end
            EXEC: begin
                retireS   = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Decode the latched opcode into writeback enable, value and flag update.
    always_comb begin
        wbEnS    = 1'b0;
        wbValS   = {DATA_W{1'b0}};
        illegalS = 1'b0;
        zeroUpdS = 1'b0;
        case (opQ)
            3'b000, 3'b001, 3'b010, 3'b011, 3'b111: begin
                wbEnS    = 1'b1;
                wbValS   = bus.alu_result;
                zeroUpdS = 1'b1;
            end
            3'b100: begin
                wbEnS  = 1'b1;
                wbValS = immQ;
            end
            default: begin
                illegalS = 1'b1;
            end
        endcase
    end

    // Latch instruction/operands on accept and capture retire status.
    always_ff @(posedge clk) begin
        if (rst) begin
            opQ     <= 3'b000;
            rdQ     <= {AW{1'b0}};
            immQ    <= {DATA_W{1'b0}};
            aQ      <= {DATA_W{1'b0}};
            bQ      <= {DATA_W{1'b0}};
            doneQ   <= 1'b0;
            errQ    <= 1'b0;
            wbDataQ <= {DATA_W{1'b0}};
            zeroQ   <= 1'b0;
        end else begin
            doneQ <= retireS;
            errQ  <= retireS & illegalS;
            if (acceptS) begin
                opQ  <= bus.in_op;
                rdQ  <= bus.in_rd;
                immQ <= bus.in_imm;
                aQ   <= rf[bus.in_rs1];
                bQ   <= rf[bus.in_rs2];
            end
            if (retireS) begin
                wbDataQ <= wbValS;
                if (zeroUpdS) begin
                    zeroQ <= bus.alu_zeroFlag;
                end
            end
        end
    end

    // Register file: cleared on reset, written once per retired legal op.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= {DATA_W{1'b0}};
            end
        end else if (retireS && wbEnS) begin
            rf[rdQ] <= wbValS;
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.alu_funSel = opQ;
    assign bus.alu_a      = aQ;
    assign bus.alu_b      = bQ;
    assign bus.done       = doneQ;
    assign bus.err        = errQ;
    assign bus.wb_data    = wbDataQ;
    assign bus.zero       = zeroQ;
    assign bus.dbg_data   = rf[bus.dbg_addr];
endmodule

// File: tb/tb_alu8_issue_wb.sv
// Directed bench for alu8_issue_wb; a small alu8 model closes the ALU loop.
module tb_alu8_issue_wb;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    alu8_issue_wb_if #(.DATA_W(8), .NREG(8)) bus ();

    alu8_issue_wb #(.DATA_W(8), .NREG(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference alu8 behaviour
    logic [7:0] aluR;
    always_comb begin
        aluR = 8'h00;
        case (bus.alu_funSel)
            3'b000:  aluR = bus.alu_a & bus.alu_b;
            3'b001:  aluR = bus.alu_a | bus.alu_b;
            3'b010:  aluR = bus.alu_a + bus.alu_b;
            3'b011:  aluR = bus.alu_a - bus.alu_b;
            3'b111:  aluR = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 8'h01 : 8'h00;
            default: aluR = 8'h00;
        endcase
    end
    assign bus.alu_result   = aluR;
    assign bus.alu_zeroFlag = (aluR == 8'h00);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkReg(input logic [2:0] idx, input logic [7:0] exp);
        bus.dbg_addr = idx;
        #1;
        chk($sformatf("rf[%0d]", idx), bus.dbg_data, exp);
    endtask

    // Issue one instruction and follow it through EXEC to the done pulse.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [7:0] imm,
                         input logic [7:0] expA, input logic [7:0] expB);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rd    = rd;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_imm   = imm;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_op    = 3'b110;
        bus.in_rd    = 3'd0;
        bus.in_imm   = 8'hEE;
        chk("exec_ready", bus.in_ready, 1'b0);
        chk("exec_done", bus.done, 1'b0);
        chk("exec_fun", bus.alu_funSel, op);
        chk("exec_a", bus.alu_a, expA);
        chk("exec_b", bus.alu_b, expB);
        @(posedge clk); #1;
        chk("ret_done", bus.done, 1'b1);
        chk("ret_ready", bus.in_ready, 1'b1);
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_op    = 3'b000;
        bus.in_rd    = 3'd0;
        bus.in_rs1   = 3'd0;
        bus.in_rs2   = 3'd0;
        bus.in_imm   = 8'h00;
        bus.dbg_addr = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.in_ready, 1'b1);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_wb", bus.wb_data, 8'h00);
        chk("rst_zero", bus.zero, 1'b0);
        chk("rst_fun", bus.alu_funSel, 3'b000);
        chk("rst_a", bus.alu_a, 8'h00);
        chk("rst_b", bus.alu_b, 8'h00);
        rst = 1'b0;

        // LDI r1=CC, LDI r2=AA, AND r3=r1&r2 -> 88
        issue(3'b100, 3'd1, 3'd0, 3'd0, 8'hCC, 8'h00, 8'h00);
        chk("ldi_wb", bus.wb_data, 8'hCC);
        issue(3'b100, 3'd2, 3'd0, 3'd0, 8'hAA, 8'h00, 8'h00);
        issue(3'b000, 3'd3, 3'd1, 3'd2, 8'h00, 8'hCC, 8'hAA);
        chk("and_wb", bus.wb_data, 8'h88);
        chk("and_err", bus.err, 1'b0);
        chk("and_zero", bus.zero, 1'b0);
        chkReg(3'd3, 8'h88);
        @(posedge clk); #1;
        chk("done_one_cycle", bus.done, 1'b0);

        // SUB to zero sets the flag; LDI of zero leaves it alone
        issue(3'b100, 3'd5, 3'd0, 3'd0, 8'h04, 8'h00, 8'h00);
        issue(3'b011, 3'd4, 3'd5, 3'd5, 8'h00, 8'h04, 8'h04);
        chk("sub_wb", bus.wb_data, 8'h00);
        chk("sub_zero", bus.zero, 1'b1);
        chkReg(3'd4, 8'h00);
        issue(3'b100, 3'd6, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00);
        chk("ldi_keeps_zero", bus.zero, 1'b1);

        // SLT both ways
        issue(3'b100, 3'd1, 3'd0, 3'd0, 8'h02, 8'h00, 8'h00);
        issue(3'b100, 3'd2, 3'd0, 3'd0, 8'h04, 8'h00, 8'h00);
        issue(3'b111, 3'd3, 3'd1, 3'd2, 8'h00, 8'h02, 8'h04);
        chk("slt1_wb", bus.wb_data, 8'h01);
        chk("slt1_zero", bus.zero, 1'b0);
        chkReg(3'd3, 8'h01);
        issue(3'b111, 3'd3, 3'd2, 3'd1, 8'h00, 8'h04, 8'h02);
        chk("slt0_wb", bus.wb_data, 8'h00);
        chk("slt0_zero", bus.zero, 1'b1);
        chkReg(3'd3, 8'h00);

        // Back-to-back ADD r1=r1+r1 with in_valid held high
        issue(3'b100, 3'd1, 3'd0, 3'd0, 8'h81, 8'h00, 8'h00);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = 3'b010;
        bus.in_rd    = 3'd1;
        bus.in_rs1   = 3'd1;
        bus.in_rs2   = 3'd1;
        @(posedge clk); #1;
        chk("b2b_ready0", bus.in_ready, 1'b0);
        chk("b2b_a0", bus.alu_a, 8'h81);
        @(posedge clk); #1;
        chk("b2b_ready1", bus.in_ready, 1'b1);
        chk("b2b_done1", bus.done, 1'b1);
        chk("b2b_wb1", bus.wb_data, 8'h02);
        chk("b2b_zero1", bus.zero, 1'b0);
        @(posedge clk); #1;
        chk("b2b_ready2", bus.in_ready, 1'b0);
        chk("b2b_a2", bus.alu_a, 8'h02);
        chk("b2b_b2", bus.alu_b, 8'h02);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b_done2", bus.done, 1'b1);
        chk("b2b_wb2", bus.wb_data, 8'h04);
        chkReg(3'd1, 8'h04);

        // Illegal opcode: err with done, wb 0, r7 and zero untouched
        issue(3'b100, 3'd7, 3'd0, 3'd0, 8'h5A, 8'h00, 8'h00);
        issue(3'b011, 3'd4, 3'd5, 3'd5, 8'h00, 8'h04, 8'h04);
        chk("pre_ill_zero", bus.zero, 1'b1);
        issue(3'b101, 3'd7, 3'd0, 3'd0, 8'h33, 8'h00, 8'h00);
        chk("ill_err", bus.err, 1'b1);
        chk("ill_wb", bus.wb_data, 8'h00);
        chk("ill_zero", bus.zero, 1'b1);
        chkReg(3'd7, 8'h5A);
        @(posedge clk); #1;
        chk("ill_err_pulse", bus.err, 1'b0);

        // Reset during EXEC discards the instruction
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = 3'b010;
        bus.in_rd    = 3'd3;
        bus.in_rs1   = 3'd1;
        bus.in_rs2   = 3'd2;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("mid_ready", bus.in_ready, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_done", bus.done, 1'b0);
        chk("mid_rst_zero", bus.zero, 1'b0);
        chk("mid_rst_wb", bus.wb_data, 8'h00);
        for (int i = 0; i < 8; i++) chkReg(3'(i), 8'h00);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", bus.in_ready, 1'b1);
        chk("post_rst_done", bus.done, 1'b0);

        // Block is live again after reset
        issue(3'b100, 3'd2, 3'd0, 3'd0, 8'h11, 8'h00, 8'h00);
        chkReg(3'd2, 8'h11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
